// File: rtl/bus_burst_sram_slave.sv
// bus_burst_sram_slave: burst-protocol bus target answering single/burst reads and writes from a word SRAM.
// Optional feature macro BUS_SLAVE_BUSY_INJECT_EN: stall one cycle after every second accepted write beat.
module bus_burst_sram_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_BITS    = 10,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transaction_in,
    input  logic        end_transaction_in,
    input  logic        read_n_write_in,
    input  logic [31:0] address_data_in,
    input  logic [3:0]  byte_enables_in,
    input  logic [7:0]  burst_size_in,
    input  logic        data_valid_in,
    output logic [31:0] address_data_out,
    output logic        data_valid_out,
    output logic        end_transaction_out,
    output logic        busy_out,
    output logic        error_out
);

    localparam int          DATA_W = 32;
    localparam int unsigned DEPTH  = 2 ** ADDR_BITS;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] RD_END  = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] ERROR   = 3'd5;

    logic [2:0]           state;
    logic [1:0]           wait_cnt;
    logic [ADDR_BITS-1:0] idx_q;
    logic [8:0]           beat_cnt;
    logic [7:0]           burst_q;
    logic [3:0]           be_q;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    rdata_p0;

    logic [31:0] offset;
    logic [31:0] word_off;
    logic [31:0] last_word;
    logic        selected;
    logic        overflow;
    logic        wait_done;
    logic        rd_last;
    logic        wr_room;
    logic        accept;
    logic        wr_en;
    logic        rd_en;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [3:0]        lanes
    );
        logic [DATA_W-1:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = lanes[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

    // Address decode and burst range check on the begin cycle
    always_comb begin
        offset    = address_data_in - BASE_ADDRESS;
        word_off  = offset >> 2;
        last_word = word_off + {24'd0, burst_size_in};
        selected  = begin_transaction_in && (address_data_in >= BASE_ADDRESS) && (word_off < DEPTH);
        overflow  = last_word >= DEPTH;
    end

    assign wait_done = (wait_cnt == 2'(READ_LATENCY - 1));
    assign rd_last   = (beat_cnt == {1'b0, burst_q});
    assign wr_room   = (beat_cnt <= {1'b0, burst_q});
    assign accept    = (state == WR_DATA) && data_valid_in && !busy_out;
    assign wr_en     = accept && wr_room;
    assign rd_en     = ((state == RD_WAIT) && wait_done) || ((state == RD_DATA) && !rd_last);

`ifdef BUS_SLAVE_BUSY_INJECT_EN
    logic busy_q;
    logic pair_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            pair_q <= 1'b0;
        end else if (state != WR_DATA) begin
            busy_q <= 1'b0;
            pair_q <= 1'b0;
        end else begin
            busy_q <= accept && pair_q;
            if (accept) begin
                pair_q <= !pair_q;
            end
        end
    end

    assign busy_out = busy_q && (state == WR_DATA);
`else
    assign busy_out = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            beat_cnt <= '0;
            burst_q  <= '0;
            be_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (selected) begin
                        idx_q    <= word_off[ADDR_BITS-1:0];
                        burst_q  <= burst_size_in;
                        be_q     <= byte_enables_in;
                        beat_cnt <= '0;
                        wait_cnt <= '0;
                        if (overflow) begin
                            state <= ERROR;
                        end else if (read_n_write_in) begin
                            state <= RD_WAIT;
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                end
                RD_WAIT: begin
                    if (wait_done) begin
                        state <= RD_DATA;
                        idx_q <= idx_q + ADDR_BITS'(1);
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RD_DATA: begin
                    if (rd_last) begin
                        state <= RD_END;
                    end else begin
                        idx_q    <= idx_q + ADDR_BITS'(1);
                        beat_cnt <= beat_cnt + 9'd1;
                    end
                end
                RD_END: state <= IDLE;
                WR_DATA: begin
                    // A beat presented together with end is still written before leaving
                    if (wr_en) begin
                        idx_q    <= idx_q + ADDR_BITS'(1);
                        beat_cnt <= beat_cnt + 9'd1;
                    end
                    if (end_transaction_in) begin
                        state <= IDLE;
                    end
                end
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[idx_q] <= merge_bytes(mem[idx_q], address_data_in, be_q);
        end
    end

    // Stage p0: registered SRAM read word, presented while in RD_DATA
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rdata_p0 <= mem[idx_q];
        end
    end

    assign data_valid_out      = (state == RD_DATA);
    assign address_data_out    = data_valid_out ? rdata_p0 : '0;
    assign end_transaction_out = (state == RD_END);
    assign error_out           = (state == ERROR);

endmodule

// File: tb/tb_bus_burst_sram_slave.sv
// Directed self-checking bench for bus_burst_sram_slave (default parameters).
module tb_bus_burst_sram_slave;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int          DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        begin_i;
    logic        end_i;
    logic        rnw;
    logic [31:0] adi;
    logic [3:0]  be;
    logic [7:0]  bs;
    logic        dvi;
    logic [31:0] address_data_out;
    logic        data_valid_out;
    logic        end_transaction_out;
    logic        busy_out;
    logic        error_out;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] wdata [0:15];
    int          busy_cycles;
    int          busy_at [0:15];

    bus_burst_sram_slave #(
        .BASE_ADDRESS (BASE),
        .ADDR_BITS    (10),
        .READ_LATENCY (1)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .begin_transaction_in (begin_i),
        .end_transaction_in   (end_i),
        .read_n_write_in      (rnw),
        .address_data_in      (adi),
        .byte_enables_in      (be),
        .burst_size_in        (bs),
        .data_valid_in        (dvi),
        .address_data_out     (address_data_out),
        .data_valid_out       (data_valid_out),
        .end_transaction_out  (end_transaction_out),
        .busy_out             (busy_out),
        .error_out            (error_out)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        begin_i = 1'b0; end_i = 1'b0; rnw = 1'b0; adi = '0; be = '0; bs = '0; dvi = 1'b0;
    endtask

    // Drives a begin cycle; returns at the negedge of the following cycle
    task automatic start_txn(input logic rd, input logic [31:0] addr, input logic [3:0] en,
                             input logic [7:0] burst);
        begin_i = 1'b1; rnw = rd; adi = addr; be = en; bs = burst; dvi = 1'b0; end_i = 1'b0;
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] en, input logic [7:0] burst,
                            input int n);
        int   i;
        int   guard;
        logic b;
        i = 0;
        guard = 0;
        busy_cycles = 0;
        start_txn(1'b0, addr, en, burst);
        while (i < n && guard < 200) begin
            b     = busy_out;
            dvi   = 1'b1;
            adi   = wdata[i];
            end_i = (i == n - 1) && !b;
            if (b && busy_cycles < 16) begin
                busy_at[busy_cycles] = i;
                busy_cycles++;
            end
            guard++;
            @(negedge clock);
            if (!b) i++;
        end
        idle_inputs();
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL write_timeout: accepted %0d beats, need %0d", i, n);
        end
    endtask

    task automatic test_reset();
        total++; if (data_valid_out !== 1'b0) begin bad++; $display("FAIL reset_dv: got %b want 0", data_valid_out); end
        total++; if (address_data_out !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", address_data_out); end
        total++; if (end_transaction_out !== 1'b0) begin bad++; $display("FAIL reset_end: got %b want 0", end_transaction_out); end
        total++; if (error_out !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", error_out); end
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    endtask

    task automatic test_write_read_burst();
        for (int k = 0; k < 4; k++) wdata[k] = 32'(k + 1);
        do_write(BASE + 32'h100, 4'hF, 8'd3, 4);
        start_txn(1'b1, BASE + 32'h100, 4'h0, 8'd3);
        total++; if (data_valid_out !== 1'b0) begin bad++; $display("FAIL burst_wait_dv: got %b want 0", data_valid_out); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            total++;
            if (data_valid_out !== 1'b1 || address_data_out !== 32'(k + 1)) begin
                bad++; $display("FAIL burst_beat%0d: got dv=%b data=%h want dv=1 data=%h", k, data_valid_out, address_data_out, 32'(k + 1));
            end
        end
        @(negedge clock);
        total++;
        if (end_transaction_out !== 1'b1 || data_valid_out !== 1'b0 || address_data_out !== 32'd0) begin
            bad++; $display("FAIL burst_end: got end=%b dv=%b data=%h want end=1 dv=0 data=0", end_transaction_out, data_valid_out, address_data_out);
        end
        @(negedge clock);
        total++; if (end_transaction_out !== 1'b0) begin bad++; $display("FAIL burst_end_pulse: got %b want 0", end_transaction_out); end
    endtask

    task automatic test_reset_mid_burst();
        start_txn(1'b1, BASE + 32'h100, 4'h0, 8'd3);
        @(negedge clock);
        @(negedge clock);
        total++;
        if (data_valid_out !== 1'b1 || address_data_out !== 32'd2) begin
            bad++; $display("FAIL midrst_pre: got dv=%b data=%h want dv=1 data=2", data_valid_out, address_data_out);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({data_valid_out, end_transaction_out, error_out, busy_out} !== 4'b0 || address_data_out !== 32'd0) begin
            bad++; $display("FAIL midrst_outputs: got dv=%b end=%b err=%b busy=%b data=%h want all 0",
                            data_valid_out, end_transaction_out, error_out, busy_out, address_data_out);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        start_txn(1'b1, BASE + 32'h104, 4'h0, 8'd1);
        @(negedge clock);
        total++; if (address_data_out !== 32'd2) begin bad++; $display("FAIL midrst_after0: got %h want 2", address_data_out); end
        @(negedge clock);
        total++; if (address_data_out !== 32'd3) begin bad++; $display("FAIL midrst_after1: got %h want 3", address_data_out); end
        @(negedge clock);
        total++; if (end_transaction_out !== 1'b1) begin bad++; $display("FAIL midrst_after_end: got %b want 1", end_transaction_out); end
        @(negedge clock);
    endtask

    task automatic test_byte_enables();
        wdata[0] = 32'h0;
        do_write(BASE + 32'h8, 4'hF, 8'd0, 1);
        wdata[0] = 32'hAABB_CCDD;
        do_write(BASE + 32'h8, 4'b0101, 8'd0, 1);
        start_txn(1'b1, BASE + 32'h8, 4'h0, 8'd0);
        @(negedge clock);
        total++;
        if (data_valid_out !== 1'b1 || address_data_out !== 32'h00BB_00DD) begin
            bad++; $display("FAIL be_merge: got dv=%b data=%h want dv=1 data=00bb00dd", data_valid_out, address_data_out);
        end
        @(negedge clock);
        total++; if (end_transaction_out !== 1'b1) begin bad++; $display("FAIL be_end: got %b want 1", end_transaction_out); end
        @(negedge clock);
    endtask

    task automatic test_overflow();
        logic [31:0] edge_addr;
        int          act;
        edge_addr = BASE + 32'(4 * (DEPTH - 2));
        wdata[0] = 32'h1111_2222;
        wdata[1] = 32'h3333_4444;
        do_write(edge_addr, 4'hF, 8'd1, 2);
        start_txn(1'b1, edge_addr, 4'h0, 8'd3);
        total++;
        if (error_out !== 1'b1 || data_valid_out !== 1'b0) begin
            bad++; $display("FAIL ovf_rd_err: got err=%b dv=%b want err=1 dv=0", error_out, data_valid_out);
        end
        act = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (error_out || data_valid_out || end_transaction_out) act++;
        end
        total++; if (act != 0) begin bad++; $display("FAIL ovf_rd_quiet: got %0d active cycles want 0", act); end
        start_txn(1'b0, edge_addr, 4'hF, 8'd3);
        total++; if (error_out !== 1'b1) begin bad++; $display("FAIL ovf_wr_err: got %b want 1", error_out); end
        dvi = 1'b1; adi = 32'hBAD0_BAD0;
        @(negedge clock);
        total++; if (error_out !== 1'b0) begin bad++; $display("FAIL ovf_wr_pulse: got %b want 0", error_out); end
        end_i = 1'b1;
        @(negedge clock);
        idle_inputs();
        start_txn(1'b1, edge_addr, 4'h0, 8'd1);
        @(negedge clock);
        total++; if (address_data_out !== 32'h1111_2222) begin bad++; $display("FAIL ovf_keep0: got %h want 11112222", address_data_out); end
        @(negedge clock);
        total++; if (address_data_out !== 32'h3333_4444) begin bad++; $display("FAIL ovf_keep1: got %h want 33334444", address_data_out); end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_unselected();
        logic [31:0] addrs [0:2];
        logic        rds   [0:2];
        int          act;
        addrs[0] = BASE - 32'd4;             rds[0] = 1'b1;
        addrs[1] = BASE + 32'(4 * DEPTH);    rds[1] = 1'b1;
        addrs[2] = BASE + 32'(4 * DEPTH);    rds[2] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            start_txn(rds[t], addrs[t], 4'hF, 8'd0);
            act = 0;
            for (int k = 0; k < 5; k++) begin
                dvi = !rds[t]; adi = 32'h5555_AAAA; end_i = (k == 1);
                if (data_valid_out || end_transaction_out || error_out || busy_out || address_data_out != 32'd0) act++;
                @(negedge clock);
            end
            idle_inputs();
            total++; if (act != 0) begin bad++; $display("FAIL unsel_%0d: got %0d active cycles want 0", t, act); end
        end
    endtask

    task automatic test_short_long();
        for (int k = 0; k < 4; k++) wdata[k] = 32'h0;
        do_write(BASE + 32'h300, 4'hF, 8'd3, 4);
        wdata[0] = 32'hA; wdata[1] = 32'hB; wdata[2] = 32'hC;
        do_write(BASE + 32'h300, 4'hF, 8'd0, 3);
        wdata[0] = 32'hD; wdata[1] = 32'hE;
        do_write(BASE + 32'h300, 4'hF, 8'd3, 2);
        wdata[2] = 32'h0;
        start_txn(1'b1, BASE + 32'h300, 4'h0, 8'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            total++;
            if (address_data_out !== wdata[k]) begin
                bad++; $display("FAIL shortlong_%0d: got %h want %h", k, address_data_out, wdata[k]);
            end
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        start_txn(1'b1, BASE + 32'h100, 4'h0, 8'd3);
        begin_i = 1'b1; rnw = 1'b0; adi = BASE + 32'h8; be = 4'hF; bs = 8'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            begin_i = (k == 0); rnw = 1'b0; adi = BASE + 32'h8; dvi = 1'b1; end_i = 1'b1;
            total++;
            if (address_data_out !== 32'(k + 1)) begin
                bad++; $display("FAIL b2b_beat%0d: got %h want %h", k, address_data_out, 32'(k + 1));
            end
        end
        idle_inputs();
        begin_i = 1'b1; rnw = 1'b1; adi = BASE + 32'h10C; bs = 8'd0;
        @(negedge clock);
        idle_inputs();
        total++; if (end_transaction_out !== 1'b1) begin bad++; $display("FAIL b2b_end: got %b want 1", end_transaction_out); end
        @(negedge clock);
        total++;
        if (data_valid_out !== 1'b0 || end_transaction_out !== 1'b0) begin
            bad++; $display("FAIL b2b_ignored: got dv=%b end=%b want 0 0", data_valid_out, end_transaction_out);
        end
        start_txn(1'b1, BASE + 32'h10C, 4'h0, 8'd0);
        @(negedge clock);
        total++; if (address_data_out !== 32'd4) begin bad++; $display("FAIL b2b_next: got %h want 4", address_data_out); end
        @(negedge clock);
        @(negedge clock);
        start_txn(1'b1, BASE + 32'h8, 4'h0, 8'd0);
        @(negedge clock);
        total++; if (address_data_out !== 32'h00BB_00DD) begin bad++; $display("FAIL b2b_nowrite: got %h want 00bb00dd", address_data_out); end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_busy();
        for (int k = 0; k < 8; k++) wdata[k] = 32'hC0DE_0000 + 32'(k);
        do_write(BASE + 32'h200, 4'hF, 8'd7, 8);
`ifdef BUS_SLAVE_BUSY_INJECT_EN
        total++; if (busy_cycles != 3) begin bad++; $display("FAIL busy_count: got %0d want 3", busy_cycles); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (busy_at[k] != 2 * (k + 1)) begin
                bad++; $display("FAIL busy_pos%0d: got %0d want %0d", k, busy_at[k], 2 * (k + 1));
            end
        end
`else
        total++; if (busy_cycles != 0) begin bad++; $display("FAIL busy_never: got %0d want 0", busy_cycles); end
`endif
        start_txn(1'b1, BASE + 32'h200, 4'h0, 8'd7);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            total++;
            if (data_valid_out !== 1'b1 || address_data_out !== wdata[k]) begin
                bad++; $display("FAIL busy_rd%0d: got dv=%b data=%h want dv=1 data=%h", k, data_valid_out, address_data_out, wdata[k]);
            end
        end
        @(negedge clock);
        total++; if (end_transaction_out !== 1'b1) begin bad++; $display("FAIL busy_rd_end: got %b want 1", end_transaction_out); end
        @(negedge clock);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_write_read_burst();
        test_reset_mid_burst();
        test_byte_enables();
        test_overflow();
        test_unselected();
        test_short_long();
        test_back_to_back();
        test_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
